gray2rgb_stream: RTL and testbench

// - Streaming luma-to-RGB expander: inverse direction of the RGB-to-BW conversion on the video path.
// - Accepts 4-bit luma pixels via valid/ready; emits 12-bit {R,G,B} pixels via valid/ready for the VGA/display side.
// - Tracks raster position and tags start-of-frame, start-of-line and end-of-line.
// - Registered output plus 1-entry skid buffer: full throughput, no combinational ready path.

---
 rtl/gray2rgb_stream.sv | 134 +++++++++++++
 tb/tb_gray2rgb_stream.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/gray2rgb_stream.sv
// rtl/gray2rgb_stream.sv - 4-bit luma to 12-bit RGB stream expander with raster tags and skid buffer
// Optional heat-map palette: define GRAY2RGB_FALSECOLOR_EN.
module gray2rgb_stream #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [3:0]  s_luma,
  input  logic        invert,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [11:0] m_rgb,
  output logic        m_sof,
  output logic        m_sol,
  output logic        m_eol,
  output logic        frame_done
);

  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          inv_frame;

  logic          skid_full;
  logic [3:0]    skid_luma;
  logic          skid_sof, skid_sol, skid_eol, skid_last;
  logic          m_last;

  logic          first, x_last, y_last, inv_eff;
  logic [3:0]    in_luma;
  logic          in_xfer, out_xfer, out_free;

  logic [3:0]    ld_luma;
  logic          ld_sof, ld_sol, ld_eol, ld_last;

  // Palette is applied when a pixel enters the output register, so it adds no latency.
  function automatic logic [11:0] colour_map(input logic [3:0] l);
`ifdef GRAY2RGB_FALSECOLOR_EN
    if (!l[3])
      colour_map = {l[2:0], 1'b0, 4'h0, ~{l[2:0], 1'b0}};
    else
      colour_map = {4'hF, l[2:0], 1'b1, 4'h0};
`else
    colour_map = {l, l, l};
`endif
  endfunction

  assign s_ready  = !skid_full;
  assign in_xfer  = s_valid && s_ready;
  assign out_xfer = m_valid && m_ready;
  assign out_free = !m_valid || m_ready;

  assign first   = (x == '0) && (y == '0);
  assign x_last  = (x == XW'(H_PIXELS - 1));
  assign y_last  = (y == YW'(V_LINES - 1));
  // The first pixel of a frame must already see the invert value it latches.
  assign inv_eff = first ? invert : inv_frame;
  assign in_luma = inv_eff ? ~s_luma : s_luma;

  always_comb begin
    ld_luma = in_luma;
    ld_sof  = first;
    ld_sol  = (x == '0);
    ld_eol  = x_last;
    ld_last = x_last && y_last;
    if (skid_full) begin
      ld_luma = skid_luma;
      ld_sof  = skid_sof;
      ld_sol  = skid_sol;
      ld_eol  = skid_eol;
      ld_last = skid_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x          <= '0;
      y          <= '0;
      inv_frame  <= 1'b0;
      skid_full  <= 1'b0;
      skid_luma  <= 4'h0;
      skid_sof   <= 1'b0;
      skid_sol   <= 1'b0;
      skid_eol   <= 1'b0;
      skid_last  <= 1'b0;
      m_valid    <= 1'b0;
      m_rgb      <= 12'h000;
      m_sof      <= 1'b0;
      m_sol      <= 1'b0;
      m_eol      <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_xfer && m_last;

      if (in_xfer) begin
        if (first)
          inv_frame <= invert;
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end

      // s_ready is low while the skid is full, so no input arrives in that branch.
      if (out_free && (skid_full || in_xfer)) begin
        m_valid   <= 1'b1;
        m_rgb     <= colour_map(ld_luma);
        m_sof     <= ld_sof;
        m_sol     <= ld_sol;
        m_eol     <= ld_eol;
        m_last    <= ld_last;
        skid_full <= 1'b0;
      end else if (in_xfer) begin
        skid_full <= 1'b1;
        skid_luma <= in_luma;
        skid_sof  <= first;
        skid_sol  <= (x == '0);
        skid_eol  <= x_last;
        skid_last <= x_last && y_last;
      end else if (out_free) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray2rgb_stream.sv
// tb/tb_gray2rgb_stream.sv - directed self-checking bench for gray2rgb_stream (4x2 raster)
module tb_gray2rgb_stream;
  localparam int H = 4;
  localparam int V = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, invert, m_valid, m_ready;
  logic [3:0]  s_luma;
  logic [11:0] m_rgb;
  logic        m_sof, m_sol, m_eol, frame_done;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  int          mx, my, out_count, done_cnt;
  logic        minv, done_next, held_v;
  logic [15:0] held;

  always #5 clk = ~clk;

  gray2rgb_stream #(.H_PIXELS(H), .V_LINES(V)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_luma(s_luma), .invert(invert),
    .m_valid(m_valid), .m_ready(m_ready), .m_rgb(m_rgb),
    .m_sof(m_sof), .m_sol(m_sol), .m_eol(m_eol), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] colour(input logic [3:0] l);
`ifdef GRAY2RGB_FALSECOLOR_EN
    if (l < 4'd8) colour = {4'(2 * l), 4'h0, 4'(15 - 2 * l)};
    else          colour = {4'hF, 4'(2 * (l - 8) + 1), 4'h0};
`else
    colour = {l, l, l};
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mx = 0; my = 0; minv = 1'b0; held_v = 1'b0; done_next = 1'b0;
  endtask

  // One clock: drive inputs, score the transfers that happen at the coming edge.
  task automatic cyc(input logic sv, input logic [3:0] lum, input logic inv, input logic mr);
    logic [15:0] e;
    logic [3:0]  l;
    logic        iv;
    s_valid = sv; s_luma = lum; invert = inv; m_ready = mr;
    if (held_v)
      check("hold", {m_valid, m_rgb, m_sof, m_sol, m_eol}, held);
    held_v = m_valid && !mr;
    held   = {m_valid, m_rgb, m_sof, m_sol, m_eol};
    done_next = 1'b0;
    if (m_valid && mr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", m_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("rgb", m_rgb, e[15:4]);
        check("tags", {m_sof, m_sol, m_eol}, e[3:1]);
        done_next = e[0];
        out_count++;
      end
    end
    if (sv && s_ready) begin
      iv = (mx == 0 && my == 0) ? inv : minv;
      if (mx == 0 && my == 0) minv = inv;
      l = iv ? 4'd15 - lum : lum;
      e = {colour(l), 1'(mx == 0 && my == 0), 1'(mx == 0), 1'(mx == H - 1),
           1'(mx == H - 1 && my == V - 1)};
      exp_q.push_back(e);
      if (mx == H - 1) begin
        mx = 0;
        my = (my == V - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    @(posedge clk); #1;
    check("frame_done", frame_done, done_next);
    if (frame_done) done_cnt++;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      cyc(1'b0, 4'h0, 1'b0, 1'b1);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic finish_frame(input logic inv);
    int n = 0;
    while (!(mx == 0 && my == 0) && n < 20) begin
      cyc(1'b1, 4'h5, inv, 1'b1);
      n++;
    end
  endtask

  logic [3:0]  pal_in  [4] = '{4'h0, 4'h7, 4'h8, 4'hF};
`ifdef GRAY2RGB_FALSECOLOR_EN
  logic [11:0] pal_exp [4] = '{12'h00F, 12'hE01, 12'hF10, 12'hFF0};
  localparam logic [11:0] INV3 = 12'hF90;
`else
  logic [11:0] pal_exp [4] = '{12'h000, 12'h777, 12'h888, 12'hFFF};
  localparam logic [11:0] INV3 = 12'hCCC;
`endif

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_luma = 4'h0; invert = 1'b0; m_ready = 1'b0;
    out_count = 0; done_cnt = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_rgb", m_rgb, 0);
    check("rst_tags", {m_sof, m_sol, m_eol}, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_s_ready", s_ready, 1);
    rst_n = 1'b1;

    // First pixel, then two full frames.
    cyc(1'b1, 4'h9, 1'b0, 1'b1);
`ifdef GRAY2RGB_FALSECOLOR_EN
    check("first_rgb", m_rgb, 12'hF30);
`else
    check("first_rgb", m_rgb, 12'h999);
`endif
    check("first_sof_sol", {m_valid, m_sof, m_sol}, 3'b111);
    for (int i = 1; i < 16; i++) cyc(1'b1, 4'(i), 1'b0, 1'b1);
    drain();
    check("two_frames_out", out_count, 16);
    check("two_frames_done", done_cnt, 2);

    // Downstream stall: one pixel parks in the skid, s_ready drops.
    cyc(1'b1, 4'h1, 1'b0, 1'b1);
    cyc(1'b1, 4'h2, 1'b0, 1'b0);
    cyc(1'b1, 4'h3, 1'b0, 1'b0);
    cyc(1'b1, 4'h3, 1'b0, 1'b0);
    check("stall_s_ready", s_ready, 0);
    check("stall_out", m_rgb, colour(4'h1));
    cyc(1'b1, 4'h3, 1'b0, 1'b1);
    cyc(1'b1, 4'h3, 1'b0, 1'b1);
    finish_frame(1'b0);
    drain();

    // Invert latched at start of frame; mid-frame toggle ignored.
    cyc(1'b1, 4'h3, 1'b1, 1'b1);
    check("inv_first", m_rgb, INV3);
    cyc(1'b1, 4'h3, 1'b0, 1'b1);
    check("inv_mid_ignored", m_rgb, INV3);
    finish_frame(1'b0);
    cyc(1'b1, 4'h3, 1'b0, 1'b1);
    check("inv_next_frame", m_rgb, colour(4'h3));
    finish_frame(1'b0);
    drain();

    // Colour map corner values.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, pal_in[i], 1'b0, 1'b1);
      check("palette", m_rgb, pal_exp[i]);
    end
    drain();

    // Reset mid-line with the skid full.
    cyc(1'b1, 4'h1, 1'b0, 1'b1);
    cyc(1'b1, 4'h2, 1'b0, 1'b0);
    check("skid_full_ready", s_ready, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_m_valid", m_valid, 0);
    check("async_rst_s_ready", s_ready, 1);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b1, 4'h6, 1'b0, 1'b1);
    check("post_rst_sof", {m_valid, m_sof, m_sol}, 3'b111);
    check("post_rst_rgb", m_rgb, colour(4'h6));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
